// File: rtl/picorv32_mem_responder.sv
// picorv32_mem_responder: picorv32 native-bus RAM plus UART/LED MMIO responder.
// Define MEM_RESP_BUS_ERR_EN to enable bus_err pulses and the ERR_ADDR register.
module picorv32_mem_responder #(
  parameter int RAM_WORDS = 4096,
  parameter int TX_DEPTH = 4,
  parameter logic [31:0] MMIO_BASE = 32'h1000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid,
  input  logic        mem_instr,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic [31:0] mem_rdata,
  output logic        mem_ready,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  input  logic        tx_busy,
  output logic [7:0]  led,
  output logic        bus_err
);
  localparam int RW = $clog2(RAM_WORDS);
  localparam int TW = $clog2(TX_DEPTH);
  localparam logic [29:0] MW = MMIO_BASE[31:2];
  typedef enum logic {IDLE, RESP} state_t;
  state_t state;
  logic [31:0] ram [RAM_WORDS];
  logic [7:0] fifo [TX_DEPTH];
  logic [TW-1:0] wr_ptr, rd_ptr;
  logic [TW:0] count;
  logic [1:0] hold;
  logic [7:0] rx_buf;
  logic rx_full, overrun;
  logic [29:0] word;
  logic is_ram, is_data, is_stat, is_led, is_err, err_map, unmapped, wr, w0;
  logic full, empty, accept, push, pop, rd_data;
  logic [31:0] rdata, err_rd;
  logic unused;
  assign unused = &{1'b0, mem_instr, mem_addr[1:0]};
  assign word = mem_addr[31:2];
  assign is_ram = word < 30'(RAM_WORDS);
  assign is_data = word == MW;
  assign is_stat = word == MW + 30'd1;
  assign is_led = word == MW + 30'd2;
  assign is_err = word == MW + 30'd3;
  assign unmapped = !(is_ram || is_data || is_stat || is_led || (is_err && err_map));
  assign wr = |mem_wstrb;
  assign w0 = mem_wstrb[0];
  assign full = count == (TW+1)'(TX_DEPTH);
  assign empty = count == '0;
  // Only a byte push into a full FIFO has to wait; everything else completes at once.
  assign accept = state == IDLE && mem_valid && !(is_data && w0 && full);
  assign push = accept && is_data && w0;
  assign pop = !empty && !tx_busy && hold == 2'd0;
  assign rd_data = accept && is_data && !wr;
  always_comb begin
    rdata = is_ram ? ram[word[RW-1:0]]
          : is_data ? {23'b0, rx_full, rx_buf}
          : is_stat ? {28'b0, overrun, rx_full, empty, full}
          : is_led ? {24'b0, led}
          : err_rd;
  end
`ifdef MEM_RESP_BUS_ERR_EN
  logic [31:0] err_addr;
  logic err_valid;
  assign err_map = 1'b1;
  assign err_rd = is_err ? err_addr : 32'b0;
  always_ff @(posedge clk) begin
    if (rst) begin
      bus_err <= 1'b0;
      err_valid <= 1'b0;
      err_addr <= '0;
    end else begin
      bus_err <= accept && unmapped;
      if (accept && unmapped && !err_valid) begin
        err_valid <= 1'b1;
        err_addr <= mem_addr;
      end
      if (accept && is_err && wr) err_valid <= 1'b0;
    end
  end
`else
  assign err_map = 1'b0;
  assign err_rd = 32'b0;
  assign bus_err = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      mem_ready <= 1'b0;
      mem_rdata <= '0;
      tx_start <= 1'b0;
      tx_data <= '0;
      led <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      hold <= '0;
      rx_buf <= '0;
      rx_full <= 1'b0;
      overrun <= 1'b0;
    end else begin
      state <= accept ? RESP : IDLE;
      mem_ready <= accept;
      if (accept) mem_rdata <= rdata;
      tx_start <= pop;
      if (pop) tx_data <= fifo[rd_ptr];
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      count <= count + (TW+1)'(push) - (TW+1)'(pop);
      // Holdoff spans the start cycle and the next, until the uart raises tx_busy.
      hold <= pop ? 2'd2 : (hold != 2'd0 ? hold - 2'd1 : 2'd0);
      if (accept && is_led && w0) led <= mem_wdata[7:0];
      if (accept && is_stat && w0 && mem_wdata[3]) overrun <= 1'b0;
      if (rx_valid && (!rx_full || rd_data)) begin
        rx_buf <= rx_data;
        rx_full <= 1'b1;
      end else if (rx_valid) overrun <= 1'b1;
      else if (rd_data) rx_full <= 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (accept && is_ram && !rst)
      for (int i = 0; i < 4; i++)
        if (mem_wstrb[i]) ram[word[RW-1:0]][8*i +: 8] <= mem_wdata[8*i +: 8];
    if (push) fifo[wr_ptr] <= mem_wdata[7:0];
  end
endmodule

// File: tb/tb_picorv32_mem_responder.sv
// tb_picorv32_mem_responder: directed checks of RAM, UART TX/RX, LED, reset and unmapped access.
module tb_picorv32_mem_responder;
  logic clk = 0, rst = 0, mem_valid = 0, mem_instr = 0, rx_valid = 0, tx_busy = 0;
  logic [31:0] mem_addr = 0, mem_wdata = 0;
  logic [3:0] mem_wstrb = 0;
  logic [7:0] rx_data = 0;
  logic [31:0] mem_rdata;
  logic mem_ready, tx_start, bus_err;
  logic [7:0] tx_data, led;
  int n_cmp = 0, n_bad = 0, n_be = 0;
  logic [7:0] txq [$];
  localparam logic [31:0] MB = 32'h1000_0000;

  picorv32_mem_responder dut (
    .clk(clk), .rst(rst), .mem_valid(mem_valid), .mem_instr(mem_instr),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .rx_valid(rx_valid),
    .rx_data(rx_data), .tx_data(tx_data), .tx_start(tx_start),
    .tx_busy(tx_busy), .led(led), .bus_err(bus_err)
  );

  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (tx_start) txq.push_back(tx_data);
    if (bus_err) n_be++;
  end

  task automatic access(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                        output logic [31:0] r, output int lat, output logic be);
    mem_valid = 1; mem_addr = a; mem_wdata = d; mem_wstrb = s;
    lat = 0; r = 0; be = 0;
    do begin @(posedge clk); #1; lat++; end while (!mem_ready && lat < 50);
    if (mem_ready) begin r = mem_rdata; be = bus_err; end
    mem_valid = 0; mem_wstrb = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst = 1; repeat (3) @(posedge clk); #1; rst = 0;
    n_cmp++; if (mem_ready !== 1'b0) begin n_bad++; $display("FAIL rst_ready got %b want 0", mem_ready); end
    n_cmp++; if (mem_rdata !== 32'h0) begin n_bad++; $display("FAIL rst_rdata got %h want 0", mem_rdata); end
    n_cmp++; if ({tx_start, tx_data, led, bus_err} !== 18'h0) begin n_bad++;
      $display("FAIL rst_outs got %b %h %h %b want zeros", tx_start, tx_data, led, bus_err); end
  endtask

  task automatic test_ram;
    logic [31:0] r; int lat; logic be;
    access(32'h10, 32'hDEADBEEF, 4'b1111, r, lat, be);
    n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL ram_w1_lat got %0d want 1", lat); end
    access(32'h10, 32'h0000_5500, 4'b0010, r, lat, be);
    n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL ram_w2_lat got %0d want 1", lat); end
    access(32'h10, 0, 4'b0000, r, lat, be);
    n_cmp++; if (r !== 32'hDEAD55EF) begin n_bad++; $display("FAIL ram_rd got %h want DEAD55EF", r); end
    n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL ram_rd_lat got %0d want 1", lat); end
    access(32'h3FFC, 32'h1234_5678, 4'b1111, r, lat, be);
    access(32'h3FFC, 0, 4'b0000, r, lat, be);
    n_cmp++; if (r !== 32'h1234_5678) begin n_bad++; $display("FAIL ram_last got %h want 12345678", r); end
  endtask

  task automatic test_tx;
    logic [31:0] r; int lat; logic be; logic stalled_ok; int w;
    tx_busy = 1;
    for (int i = 0; i < 4; i++) begin
      access(MB, 32'h41 + i, 4'b0001, r, lat, be);
      n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL tx_w%0d_lat got %0d want 1", i, lat); end
    end
    access(MB + 4, 0, 4'b0000, r, lat, be);
    n_cmp++; if (r !== 32'h1) begin n_bad++; $display("FAIL tx_stat_full got %h want 1", r); end
    mem_valid = 1; mem_addr = MB; mem_wdata = 32'h45; mem_wstrb = 4'b0001;
    stalled_ok = 1;
    repeat (5) begin @(posedge clk); #1; if (mem_ready) stalled_ok = 0; end
    n_cmp++; if (stalled_ok !== 1'b1) begin n_bad++; $display("FAIL tx_stall got ready=1 want ready=0"); end
    tx_busy = 0; w = 0;
    while (!mem_ready && w < 20) begin @(posedge clk); #1; w++; end
    n_cmp++; if (mem_ready !== 1'b1) begin n_bad++; $display("FAIL tx_unstall got %b want 1", mem_ready); end
    mem_valid = 0; mem_wstrb = 0;
    repeat (30) @(posedge clk); #1;
    n_cmp++; if (txq.size() !== 5) begin n_bad++; $display("FAIL tx_count got %0d want 5", txq.size()); end
    for (int i = 0; i < 5; i++) begin
      logic [7:0] e, g;
      e = 8'h41 + 8'(i); g = (i < txq.size()) ? txq[i] : 8'hxx;
      n_cmp++; if (g !== e) begin n_bad++; $display("FAIL tx_byte%0d got %h want %h", i, g, e); end
    end
  endtask

  task automatic rx_pulse(input logic [7:0] b);
    rx_valid = 1; rx_data = b; @(posedge clk); #1; rx_valid = 0;
  endtask

  task automatic test_rx;
    logic [31:0] r; int lat; logic be;
    rx_pulse(8'h5A); rx_pulse(8'h33);
    access(MB + 4, 0, 4'b0000, r, lat, be);
    n_cmp++; if (r !== 32'hE) begin n_bad++; $display("FAIL rx_stat1 got %h want E", r); end
    access(MB, 0, 4'b0000, r, lat, be);
    n_cmp++; if (r !== 32'h15A) begin n_bad++; $display("FAIL rx_data got %h want 15A", r); end
    access(MB + 4, 0, 4'b0000, r, lat, be);
    n_cmp++; if (r !== 32'hA) begin n_bad++; $display("FAIL rx_stat2 got %h want A", r); end
    access(MB + 4, 32'h8, 4'b0001, r, lat, be);
    access(MB + 4, 0, 4'b0000, r, lat, be);
    n_cmp++; if (r !== 32'h2) begin n_bad++; $display("FAIL rx_stat3 got %h want 2", r); end
    rx_pulse(8'h77);
    mem_valid = 1; mem_addr = MB; mem_wstrb = 0; rx_valid = 1; rx_data = 8'h99;
    @(posedge clk); #1; rx_valid = 0;
    n_cmp++; if (mem_ready !== 1'b1 || mem_rdata !== 32'h177) begin n_bad++;
      $display("FAIL rx_same_cycle got ready=%b %h want 1 177", mem_ready, mem_rdata); end
    mem_valid = 0; @(posedge clk); #1;
    access(MB + 4, 0, 4'b0000, r, lat, be);
    n_cmp++; if (r !== 32'h6) begin n_bad++; $display("FAIL rx_stat4 got %h want 6", r); end
    access(MB, 0, 4'b0000, r, lat, be);
    n_cmp++; if (r !== 32'h199) begin n_bad++; $display("FAIL rx_data2 got %h want 199", r); end
  endtask

  task automatic test_led_reset;
    logic [31:0] r; int lat; logic be;
    access(MB + 8, 32'h0000_00A5, 4'b0001, r, lat, be);
    n_cmp++; if (led !== 8'hA5) begin n_bad++; $display("FAIL led_out got %h want A5", led); end
    access(MB + 8, 0, 4'b0000, r, lat, be);
    n_cmp++; if (r !== 32'hA5) begin n_bad++; $display("FAIL led_rd got %h want A5", r); end
    rx_pulse(8'h11);
    mem_valid = 1; mem_addr = MB + 8; mem_wdata = 32'h3C; mem_wstrb = 4'b0001; rst = 1;
    @(posedge clk); #1;
    n_cmp++; if (mem_ready !== 1'b0 || led !== 8'h00) begin n_bad++;
      $display("FAIL rst_mid got ready=%b led=%h want 0 00", mem_ready, led); end
    rst = 0; mem_valid = 0; mem_wstrb = 0; @(posedge clk); #1;
    access(MB + 4, 0, 4'b0000, r, lat, be);
    n_cmp++; if (r !== 32'h2) begin n_bad++; $display("FAIL rst_stat got %h want 2", r); end
  endtask

  task automatic test_unmapped;
    logic [31:0] r; int lat; logic be; int b0;
    logic ee; logic [31:0] ea;
`ifdef MEM_RESP_BUS_ERR_EN
    ee = 1; ea = 32'h2000_0000;
`else
    ee = 0; ea = 32'h0;
`endif
    b0 = n_be;
    access(32'h2000_0000, 0, 4'b0000, r, lat, be);
    n_cmp++; if (r !== 32'h0 || lat !== 1) begin n_bad++; $display("FAIL unm_rd got %h lat %0d want 0 lat 1", r, lat); end
    n_cmp++; if (be !== ee) begin n_bad++; $display("FAIL unm_be got %b want %b", be, ee); end
    n_cmp++; if (n_be - b0 !== int'(ee)) begin n_bad++; $display("FAIL unm_be_count got %0d want %0d", n_be - b0, ee); end
    access(MB + 12, 0, 4'b0000, r, lat, be);
    n_cmp++; if (r !== ea) begin n_bad++; $display("FAIL err_addr got %h want %h", r, ea); end
    access(32'h4000, 0, 4'b0000, r, lat, be);
    n_cmp++; if (r !== 32'h0 || be !== ee) begin n_bad++; $display("FAIL unm_ram_edge got %h be %b want 0 %b", r, be, ee); end
    access(MB + 12, 0, 4'b0000, r, lat, be);
    n_cmp++; if (r !== ea) begin n_bad++; $display("FAIL err_sticky got %h want %h", r, ea); end
  endtask

  initial begin
    test_reset;
    test_ram;
    test_tx;
    test_rx;
    test_led_reset;
    test_unmapped;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
